// File: rtl/mips_avalon_bridge.sv
// Bridges the MIPS fetch and data ports onto one Avalon-MM master with byte/half/word
// lane steering, load extension, fixed-priority arbitration and a REQ-phase timeout.
module mips_avalon_bridge #(
    parameter bit          DATA_FIRST = 1'b1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int unsigned   CntW        = $clog2(TIMEOUT + 2);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    state_e         state_q, state_d;
    logic           sel_d_q, sel_d_d;
    logic [1:0]     size_q, size_d;
    logic           signed_q, signed_d;
    logic [1:0]     off_q, off_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           hold_q, hold_d;
    logic [31:0]    i_rdata_q, i_rdata_d;
    logic [31:0]    d_rdata_q, d_rdata_d;

    logic        d_want, serve_d, d_bad, i_bad, timeout_hit, done_ack;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign d_want      = d_read | d_write;
    assign serve_d     = d_want & (DATA_FIRST | ~i_req);
    assign i_bad       = i_addr[1:0] != 2'b00;
    assign d_bad       = (d_read & d_write) | (d_size == 2'b11) |
                         ((d_size == 2'b01) & d_addr[0]) |
                         ((d_size == 2'b10) & (d_addr[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

    always_comb begin
        st_wdata = d_wdata;
        st_be    = 4'b1111;
        unique case (d_size)
            2'b00: begin
                st_wdata = {4{d_wdata[7:0]}};
                st_be    = 4'b0001 << d_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{d_wdata[15:0]}};
                st_be    = d_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (off_q)
            2'd0: ld_byte = readdata[7:0];
            2'd1: ld_byte = readdata[15:8];
            2'd2: ld_byte = readdata[23:16];
            2'd3: ld_byte = readdata[31:24];
        endcase
        ld_half = off_q[1] ? readdata[31:16] : readdata[15:0];
        unique case (size_q)
            2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = readdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d_d   = sel_d_q;
        size_d    = size_q;
        signed_d  = signed_q;
        off_d     = off_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        hold_d    = hold_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                err_d  = 1'b0;
                hold_d = 1'b0;
                if (d_want || i_req) begin
                    sel_d_d = serve_d;
                    if (serve_d ? d_bad : i_bad) begin
                        // Error completions spend two DONE cycles so the ack lands two
                        // cycles after sampling without ever touching the bus.
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d  = StReq;
                        addr_d   = serve_d ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
                        wdata_d  = serve_d ? st_wdata : wdata_q;
                        be_d     = (serve_d && d_write) ? st_be : 4'b1111;
                        size_d   = serve_d ? d_size : 2'b10;
                        signed_d = serve_d & d_signed;
                        off_d    = serve_d ? d_addr[1:0] : 2'b00;
                        rd_d     = ~(serve_d & d_write);
                        wr_d     = serve_d & d_write;
                    end
                end
            end
            StReq: begin
                if (!waitrequest) begin
                    state_d = StData;
                end else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = StDone;
                if (rd_q) begin
                    if (sel_d_q) d_rdata_d = ld_data;
                    else         i_rdata_d = readdata;
                end
            end
            StDone: begin
                if (hold_q) hold_d = 1'b0;
                else        state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_d_q   <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            off_q     <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_d_q   <= sel_d_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign done_ack   = (state_q == StDone) & ~hold_q;
    assign i_ack      = done_ack & ~sel_d_q;
    assign d_ack      = done_ack & sel_d_q;
    assign i_err      = i_ack & err_q;
    assign d_err      = d_ack & err_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign address    = addr_q;
    assign read       = rd_q;
    assign write      = wr_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;

endmodule

// File: tb/tb_mips_avalon_bridge.sv
// Directed bench for mips_avalon_bridge: vector table of single accesses against a small
// Avalon slave model, plus arbitration, timeout and mid-transaction reset sequences.
module tb_mips_avalon_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_read, d_write;
    logic [1:0]  d_size;
    logic        d_signed;
    logic [31:0] d_addr, d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model: 16 words, programmable wait count, optional permanent stall.
    logic [31:0] mem [16];
    int          wcnt = 0;
    int          slave_wait = 0;
    logic        stall_all = 1'b0;
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    assign waitrequest = (read | write) & (stall_all | (wcnt < slave_wait));
    assign readdata    = mem[address[5:2]];

    always @(posedge clk) begin
        if (!(read || write)) wcnt <= 0;
        else if (waitrequest) wcnt <= wcnt + 1;
        if (pre_en) mem[pre_idx] <= pre_val;
        if (write && !waitrequest) begin
            for (int k = 0; k < 4; k++)
                if (byteenable[k]) mem[address[5:2]][8*k +: 8] <= writedata[8*k +: 8];
        end
    end

    always #5 clk = ~clk;

    mips_avalon_bridge #(
        .DATA_FIRST (1'b1),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ack       (i_ack),
        .i_rdata     (i_rdata),
        .i_err       (i_err),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_size      (d_size),
        .d_signed    (d_signed),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ack       (d_ack),
        .d_rdata     (d_rdata),
        .d_err       (d_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    typedef struct {
        logic        fetch;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        int          wait_n;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_mem;
    } vec_t;

    function automatic vec_t mk(input logic fetch, input logic rd, input logic wr,
                                input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] init, input int wait_n,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                input logic [31:0] exp_mem);
        vec_t v;
        v.fetch = fetch; v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn;
        v.addr = addr; v.wdata = wdata; v.init = init; v.wait_n = wait_n;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_mem = exp_mem;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    // Raises one request in an IDLE cycle; lat counts posedges up to and including the one
    // after which the ack is visible.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat, strb;
        logic        got, err;
        logic [31:0] rdata, a_seen, wd_seen;
        logic [3:0]  be_seen;
        lat = 0; strb = 0; got = 1'b0; err = 1'b0; rdata = '0;
        a_seen = '0; wd_seen = '0; be_seen = '0;
        @(posedge clk);
        @(negedge clk);
        pre_idx = v.addr[5:2]; pre_val = v.init; pre_en = 1'b1; slave_wait = v.wait_n;
        if (v.fetch) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_read = v.rd; d_write = v.wr; d_size = v.size; d_signed = v.sgn;
            d_addr = v.addr; d_wdata = v.wdata;
        end
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            pre_en = 1'b0;
            lat++;
            if (read || write) begin
                if (strb == 0) begin
                    a_seen = address; wd_seen = writedata; be_seen = byteenable;
                end
                strb++;
            end
            if (v.fetch ? i_ack : d_ack) begin
                got   = 1'b1;
                rdata = v.fetch ? i_rdata : d_rdata;
                err   = v.fetch ? i_err : d_err;
            end
        end
        drop_reqs();
        chk($sformatf("v%0d ack", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d latency", idx), lat, v.exp_err ? 2 : 3 + v.wait_n);
        chk($sformatf("v%0d strobe cycles", idx), strb, v.exp_err ? 0 : 2 + v.wait_n);
        if (!v.exp_err) begin
            chk($sformatf("v%0d address", idx), a_seen, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d byteenable", idx), 32'(be_seen), 32'(v.exp_be));
            if (v.wr) begin
                chk($sformatf("v%0d writedata", idx), wd_seen, v.exp_wdata);
                chk($sformatf("v%0d memory", idx), mem[v.addr[5:2]], v.exp_mem);
            end else begin
                chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
            end
        end
    endtask

    vec_t vecs [16];

    initial begin
        int          lat, strb, t_d, t_i, acks;
        logic        gap_ok, err;
        vecs[0]  = mk(1, 0, 0, 2'b10, 0, 32'hBFC00004, 0, 32'h24020005, 2,
                      0, 32'h24020005, 4'hF, 0, 0);
        vecs[1]  = mk(0, 1, 0, 2'b00, 1, 32'h13, 0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 4'hF, 0, 0);
        vecs[2]  = mk(0, 1, 0, 2'b00, 0, 32'h13, 0, 32'h80FF1234, 1, 0, 32'h00000080, 4'hF, 0, 0);
        vecs[3]  = mk(0, 0, 1, 2'b01, 0, 32'h6, 32'h0000BEEF, 32'h11223344, 1,
                      0, 0, 4'hC, 32'hBEEFBEEF, 32'hBEEF3344);
        vecs[4]  = mk(0, 1, 0, 2'b01, 1, 32'h12, 0, 32'h80FF1234, 0, 0, 32'hFFFF80FF, 4'hF, 0, 0);
        vecs[5]  = mk(0, 1, 0, 2'b01, 1, 32'h10, 0, 32'h80FF1234, 2, 0, 32'h00001234, 4'hF, 0, 0);
        vecs[6]  = mk(0, 1, 0, 2'b10, 0, 32'h8, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'hF, 0, 0);
        vecs[7]  = mk(0, 0, 1, 2'b00, 0, 32'h1, 32'h000000AB, 32'h11223344, 0,
                      0, 0, 4'h2, 32'hABABABAB, 32'h1122AB44);
        vecs[8]  = mk(0, 0, 1, 2'b10, 0, 32'hC, 32'hCAFEF00D, 32'h0, 3,
                      0, 0, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D);
        vecs[9]  = mk(0, 1, 0, 2'b00, 1, 32'h1, 0, 32'h00007F00, 0, 0, 32'h0000007F, 4'hF, 0, 0);
        vecs[10] = mk(0, 1, 0, 2'b10, 0, 32'h2, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 0, 2'b01, 0, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 2'b11, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 2'b10, 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 0, 0, 2'b10, 0, 32'h1002, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 1, 2'b00, 0, 32'h2, 32'h0000005A, 32'h11223344, 0,
                      0, 0, 4'h4, 32'h5A5A5A5A, 32'h115A3344);

        rst_n = 1'b0; i_addr = '0; d_size = 2'b10; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
        drop_reqs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset strobes", {30'd0, read, write}, 32'd0);
        chk("reset acks/errs", {28'd0, i_ack, d_ack, i_err, d_err}, 32'd0);
        chk("reset address", address, 32'd0);
        chk("reset writedata", writedata, 32'd0);
        chk("reset byteenable", 32'(byteenable), 32'd0);
        chk("reset i_rdata", i_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Both ports in the same IDLE cycle: data wins, fetch follows 4 cycles later.
        @(posedge clk);
        @(negedge clk);
        pre_idx = 4'd2; pre_val = 32'h0BADF00D; pre_en = 1'b1; slave_wait = 0;
        @(negedge clk);
        pre_idx = 4'd1; pre_val = 32'h24020005;
        @(negedge clk);
        pre_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h4;
        d_read = 1'b1; d_size = 2'b10; d_signed = 1'b0; d_addr = 32'h8;
        t_d = 0; t_i = 0; gap_ok = 1'b0;
        for (int c = 1; c <= 20 && t_i == 0; c++) begin
            @(posedge clk); #1;
            if (d_ack && t_d == 0) begin
                t_d = c; gap_ok = !read && !write; d_read = 1'b0;
                chk("arb d_rdata", d_rdata, 32'h0BADF00D);
            end
            if (i_ack) begin
                t_i = c; i_req = 1'b0;
                chk("arb i_rdata", i_rdata, 32'h24020005);
            end
        end
        drop_reqs();
        chk("arb data ack latency", t_d, 3);
        chk("arb fetch ack after data ack", t_i - t_d, 4);
        chk("arb bus gap", 32'(gap_ok), 32'd1);

        // Permanently stalled slave: abort after TIMEOUT=8 REQ cycles.
        @(posedge clk);
        @(negedge clk);
        stall_all = 1'b1;
        d_read = 1'b1; d_size = 2'b10; d_addr = 32'h0;
        lat = 0; strb = 0; err = 1'b0; gap_ok = 1'b0;
        while (lat < 30 && !d_ack) begin
            @(posedge clk); #1;
            lat++;
            if (read || write) strb++;
            if (d_ack) begin
                err = d_err; gap_ok = !read && !write;
            end
        end
        drop_reqs();
        stall_all = 1'b0;
        chk("timeout strobe cycles", strb, 8);
        chk("timeout ack latency", lat, 9);
        chk("timeout d_err", 32'(err), 32'd1);
        chk("timeout strobes low at ack", 32'(gap_ok), 32'd1);

        // Reset in the middle of REQ: everything clears at once and no ack follows.
        @(posedge clk);
        @(negedge clk);
        stall_all = 1'b1;
        d_read = 1'b1; d_size = 2'b10; d_addr = 32'h24;
        repeat (3) @(posedge clk);
        #2;
        chk("pre-reset read", 32'(read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-reset strobes", {30'd0, read, write}, 32'd0);
        chk("mid-reset address", address, 32'd0);
        chk("mid-reset byteenable", 32'(byteenable), 32'd0);
        drop_reqs();
        stall_all = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (i_ack || d_ack || read || write) acks++;
        end
        chk("no ack/strobe after reset", acks, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
